asend_arb: RTL and testbench
============================

# asend_arb

Round-robin arbiter and sequencer that shares a single asend/aack clock-domain-crossing send channel among N requesters in the aclk domain. It sits between the local requesters and the sender-side ready/busy FSM. It selects one requester, latches its data onto adata, and issues a one-cycle asend. It then holds the channel until the far side returns aack and reports completion to the owning requester.

## Interface
- N, 4, number of requesters (2..8)
- DW, 8, data width per transfer
- CW, 16, width of completed-transfer counter
- aclk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- req  in  N  per-requester transfer request, level; held until gnt
- req_data  in  N*DW  requester i data at bits [i*DW +: DW]
- gnt  out  N  one-hot, one-cycle pulse: request accepted, data captured
- done  out  N  one-hot, one-cycle pulse: owner's transfer acknowledged
- aready  in  1  sender FSM ready (1 = channel idle)
- asend  out  1  one-cycle send strobe to sender FSM
- adata  out  DW  registered transfer data, stable from asend until done
- aack  in  1  synchronized acknowledge from destination (pulse or level)
- busy  out  1  1 while state != IDLE
- xfer_cnt  out  CW  completed transfers, wraps modulo 2^CW

## Operation
- States: IDLE, SEND, WAIT. Reset state is IDLE.
- Owner register: log2(N) bits. Round-robin pointer ptr: log2(N) bits, reset 0.
- IDLE:
  - If aready=1 and req!=0, winner w = first set req bit searching ptr, ptr+1, … , wrapping modulo N.
  - On the clock edge: adata<=req_data[w], owner<=w, ptr<=(w+1) mod N, gnt[w]<=1, asend<=1, state<=SEND.
  - If aready=0 or req==0: no change; gnt/asend stay 0.
- SEND (exactly one cycle; asend=1, gnt=1 here): state<=WAIT; asend, gnt cleared. aack in SEND is ignored.
- WAIT: hold adata and owner. On aack=1: done[owner]<=1, xfer_cnt<=xfer_cnt+1, state<=IDLE.
- aack in IDLE (spurious): ignored; no done, counter unchanged.
- Requests arriving or dropping while not in IDLE are not sampled. A req dropped before being granted is lost without error.
- A requester keeping req high after gnt is treated as a new request at the next IDLE arbitration.
- busy = (state != IDLE), registered.
- Reset mid-transfer: immediately IDLE, ptr=0, owner=0, all outputs 0. The transfer in flight is abandoned with no done.
- Reset values: gnt=0, done=0, asend=0, adata=0, busy=0, xfer_cnt=0.

## Timing
- Request-to-send: req and aready high in cycle T gives asend and gnt in T+1 and busy from T+1.
- aack high in cycle A (A >= SEND+1) gives done in A+1 and state IDLE in A+1.
- Back-to-back transfers: a new arbitration can occur in A+1, giving the next asend in A+2. Minimum spacing between asends is 3 cycles (SEND, one WAIT, IDLE).
- A multi-cycle aack level completes exactly one transfer; the next transfer's WAIT begins only after SEND.
- All outputs are registered; no combinational path from inputs to outputs.
- xfer_cnt at 2^CW-1 plus one completion gives 0.

## Test plan
- Reset, then req=4'b0001, data0=8'hA5, aready=1: gnt=0001 and asend for one cycle, adata=A5; aack 4 cycles later gives done=0001 one cycle later, xfer_cnt=1.
- req=4'b1111 held, aack returned 2 cycles after each asend: grant order is 0,1,2,3,0; each adata matches its requester; no two gnts without an intervening done.
- aready=0 with req=0010 for 5 cycles: no gnt or asend. aready rises in cycle T: asend in T+1.
- aack pulsed in IDLE and in the SEND cycle: no done, state unchanged, xfer_cnt unchanged. A later aack in WAIT completes normally.
- arst_n asserted during WAIT (owner=2): all outputs 0 immediately. After release, req=0100 is granted and ptr starts at 0.
- CW=4, 17 completed transfers: xfer_cnt wraps 15 to 0 and reads 1 at the end.

Source files
------------

// File: rtl/asend_arb.sv
// asend_arb: round-robin arbiter that shares one asend/aack send channel
// among N requesters. It grants one requester, latches its data onto adata
// and pulses asend. It then holds the channel until aack arrives, and
// finally pulses done back to the owner.
module asend_arb #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic            aclk,
  input  logic            arst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  input  logic            aready,
  output logic            asend,
  output logic [DW-1:0]   adata,
  input  logic            aack,
  output logic            busy,
  output logic [CW-1:0]   xfer_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic [PW-1:0] win_next;
  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Pick the first asserted request, starting at ptr and wrapping modulo N
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Pointer position just after the winner, wrapping modulo N
  always_comb begin
    if (win == PW'(N-1))
      win_next = '0;
    else
      win_next = win + PW'(1);
  end

  // Channel sequencer: grant and send, then wait for the acknowledge and report completion
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      done     <= '0;
      asend    <= 1'b0;
      adata    <= '0;
      busy     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      gnt   <= '0;
      done  <= '0;
      asend <= 1'b0;
      case (state)
        IDLE: begin
          if (aready && found) begin
            adata      <= req_data[win*DW +: DW];
            owner      <= win;
            ptr        <= win_next;
            gnt[win]   <= 1'b1;
            asend      <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (aack) begin
            done[owner] <= 1'b1;
            xfer_cnt    <= xfer_cnt + CW'(1);
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asend_arb.sv
// tb_asend_arb: directed, table-driven bench for asend_arb (N=4, DW=8, CW=4).
// The table holds per-cycle inputs with the outputs expected after the next edge.
// The hand-written sequences that follow cover aready gating, stray aack,
// reset in the middle of a transfer, and counter wrap.
module tb_asend_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic            aclk;
  logic            arst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            aready;
  logic            asend;
  logic [DW-1:0]   adata;
  logic            aack;
  logic            busy;
  logic [CW-1:0]   xfer_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] req;
    logic       aready;
    logic       aack;
    logic [3:0] eGnt;
    logic [3:0] eDone;
    logic       eAsend;
    logic [7:0] eAdata;
    logic       eBusy;
    logic [3:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  asend_arb #(.N(N), .DW(DW), .CW(CW)) dut (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .aready   (aready),
    .asend    (asend),
    .adata    (adata),
    .aack     (aack),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  // Free-running clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic vec_t mk(logic [3:0] r, logic rdy, logic ack, logic [3:0] g, logic [3:0] d,
                              logic s, logic [7:0] a, logic b, logic [3:0] c);
    vec_t v;
    v.req = r; v.aready = rdy; v.aack = ack;
    v.eGnt = g; v.eDone = d; v.eAsend = s; v.eAdata = a; v.eBusy = b; v.eCnt = c;
    return v;
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic ack);
    req    = r;
    aready = rdy;
    aack   = ack;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eGnt, input logic [3:0] eDone,
                             input logic eAsend, input logic [7:0] eAdata, input logic eBusy,
                             input logic [3:0] eCnt);
    checkField($sformatf("%s.gnt", tag),      32'(gnt),      32'(eGnt));
    checkField($sformatf("%s.done", tag),     32'(done),     32'(eDone));
    checkField($sformatf("%s.asend", tag),    32'(asend),    32'(eAsend));
    checkField($sformatf("%s.adata", tag),    32'(adata),    32'(eAdata));
    checkField($sformatf("%s.busy", tag),     32'(busy),     32'(eBusy));
    checkField($sformatf("%s.xfer_cnt", tag), 32'(xfer_cnt), 32'(eCnt));
  endtask

  // One transfer of requester 0 with aack two cycles after asend
  task automatic oneXfer(input string tag, input logic [3:0] cntAfter);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    step();
    checkField($sformatf("%s.gnt", tag), 32'(gnt), 32'(4'b0001));
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step();
    checkField($sformatf("%s.done", tag), 32'(done), 32'(4'b0001));
    checkField($sformatf("%s.xfer_cnt", tag), 32'(xfer_cnt), 32'(cntAfter));
  endtask

  initial begin
    logic [3:0] expCnt;

    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    applyStimulus(4'b0000, 1'b0, 1'b0);
    arst_n = 1'b0;

    // Single transfer from requester 0, aack four cycles after the grant edge
    vecs.push_back(mk(4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 8'hA5, 1, 4'd0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 1, 4'd0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 1, 4'd0));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 1, 4'd0));
    vecs.push_back(mk(4'b0000, 1, 1, 4'b0000, 4'b0001, 0, 8'hA5, 0, 4'd1));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 0, 4'd1));
    // All requesting; ptr is 1 after the first grant, so the order is 1,2,3,0,1
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 8'hB1, 1, 4'd1));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 8'hB1, 1, 4'd1));
    vecs.push_back(mk(4'b1111, 1, 1, 4'b0000, 4'b0010, 0, 8'hB1, 0, 4'd2));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0100, 4'b0000, 1, 8'hC2, 1, 4'd2));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 8'hC2, 1, 4'd2));
    vecs.push_back(mk(4'b1111, 1, 1, 4'b0000, 4'b0100, 0, 8'hC2, 0, 4'd3));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b1000, 4'b0000, 1, 8'hD3, 1, 4'd3));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 8'hD3, 1, 4'd3));
    vecs.push_back(mk(4'b1111, 1, 1, 4'b0000, 4'b1000, 0, 8'hD3, 0, 4'd4));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 8'hA5, 1, 4'd4));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 8'hA5, 1, 4'd4));
    vecs.push_back(mk(4'b1111, 1, 1, 4'b0000, 4'b0001, 0, 8'hA5, 0, 4'd5));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 8'hB1, 1, 4'd5));
    vecs.push_back(mk(4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 8'hB1, 1, 4'd5));
    vecs.push_back(mk(4'b1111, 1, 1, 4'b0000, 4'b0010, 0, 8'hB1, 0, 4'd6));
    vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 8'hB1, 0, 4'd6));

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 4'd0);
    arst_n = 1'b1;

    // Table-driven portion
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].aready, vecs[i].aack);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].eGnt, vecs[i].eDone, vecs[i].eAsend,
                  vecs[i].eAdata, vecs[i].eBusy, vecs[i].eCnt);
    end

    // aready low holds off arbitration; grant follows the cycle aready rises
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0);
      step();
      checkOutput($sformatf("noready%0d", i), 4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b0, 4'd6);
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    step();
    checkOutput("readyrise", 4'b0010, 4'b0000, 1'b1, 8'hB1, 1'b1, 4'd6);

    // aack during SEND is ignored; a later aack in WAIT completes; a held level completes once
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step();
    checkOutput("ackInSend", 4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b1, 4'd6);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("waitHold", 4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b1, 4'd6);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step();
    checkOutput("ackInWait", 4'b0000, 4'b0010, 1'b0, 8'hB1, 1'b0, 4'd7);
    step();
    checkOutput("ackInIdle", 4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b0, 4'd7);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Reset asserted in WAIT with owner 2
    applyStimulus(4'b0100, 1'b1, 1'b0);
    step();
    checkOutput("gnt2", 4'b0100, 4'b0000, 1'b1, 8'hC2, 1'b1, 4'd7);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step();
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("midReset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step();
    checkOutput("resetHeld", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 4'd0);
    arst_n = 1'b1;
    // With ptr back at 0, requester 0 wins over 1..3
    applyStimulus(4'b1111, 1'b1, 1'b0);
    step();
    checkOutput("ptrReset", 4'b0001, 4'b0000, 1'b1, 8'hA5, 1'b1, 4'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step();
    checkOutput("postResetDone", 4'b0000, 4'b0001, 1'b0, 8'hA5, 1'b0, 4'd1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    step();
    checkOutput("postResetGnt2", 4'b0100, 4'b0000, 1'b1, 8'hC2, 1'b1, 4'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    step();
    checkOutput("postResetDone2", 4'b0000, 4'b0100, 1'b0, 8'hC2, 1'b0, 4'd2);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Counter wrap: 17 completions from a fresh reset end at 1
    arst_n = 1'b0;
    #3;
    checkField("wrapReset.xfer_cnt", 32'(xfer_cnt), 32'(0));
    arst_n = 1'b1;
    expCnt = 4'd0;
    for (int k = 0; k < 17; k++) begin
      expCnt = 4'((k + 1) % 16);
      oneXfer($sformatf("wrap%0d", k), expCnt);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("wrapEnd", 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
